hex_text_writer: RTL
====================

Name: hex_text_writer

Overview:
- Writer side of the on-screen text path: turns 32-bit debug values (register/PC contents) and single characters into ASCII codes and writes them into the character buffer that the VGA text renderer reads through the font ROM.
- Sequences multi-character writes over consecutive cycles behind a valid/ready request port.
- Also provides a full-screen clear.

Parameters:
- COLS, 80, text columns per row.
- ROWS, 30, text rows.
- ADDR_W, 12, character-buffer address width; must satisfy 2^ADDR_W >= COLS*ROWS.

Ports:
- Clk  input  1  system clock.
- Reset_n  input  1  asynchronous active-low reset.
- req_valid  input  1  request present.
- req_ready  output  1  block can accept a request.
- req_op  input  2  00 hex word, 01 single char, 10 clear screen, 11 reserved.
- req_row  input  5  start row.
- req_col  input  7  start column.
- req_data  input  32  hex word (op 00) or ASCII char in [7:0] (op 01).
- buf_we  output  1  character-buffer write strobe.
- buf_addr  output  ADDR_W  write address = row*COLS + col.
- buf_wdata  output  8  ASCII code to write.
- busy  output  1  high while writes are in progress.
- done  output  1  one-cycle pulse when a request completes.
- err  output  1  one-cycle pulse when a request is rejected.

Behaviour:
- Reset: asynchronous, active-low; effective immediately, including mid-operation.
  - Outputs during reset: req_ready=0, buf_we=0, buf_addr=0, buf_wdata=0, busy=0, done=0, err=0.
  - After release: FSM in IDLE, req_ready=1 from the first clock edge.
  - Any in-flight sequence is abandoned; no further writes.
- FSM states:
  - IDLE: req_ready=1, busy=0.
  - EMIT: req_ready=0, busy=1, one buf_we per cycle.
  - IDLE→EMIT on req_valid&req_ready with a valid request; EMIT→IDLE after the last write.
- Accept timing: request sampled at edge T.
  - Edges T+1..T+N drive buf_we=1 with successive characters.
  - Cycle after the last write: done=1, req_ready=1, buf_we=0.
  - No bubbles between characters.
  - A new request may be accepted in the done cycle.
- Op 00, hex word: N=10. Characters: '0' (0x30), 'x' (0x78), then nibbles [31:28] down to [3:0].
  - Nibble n<=9 → 0x30+n; n>=10 → 0x57+n (lowercase a-f).
  - req_data is latched at accept; later input changes are ignored.
- Op 01, single char: N=1, buf_wdata=req_data[7:0].
- Op 10, clear: N=COLS*ROWS. Writes 0x20 to addresses 0..COLS*ROWS-1 in ascending order; req_row/req_col are ignored.
- Position advance: col increments per character.
  - col==COLS-1 wraps to col 0, row+1.
  - row==ROWS-1 with col==COLS-1 wraps to row 0, col 0.
- buf_addr: computed from the internal row/col counters as row*COLS+col, with no truncation within ADDR_W.
- Rejection (op 11, or op 00/01 with req_row>=ROWS or req_col>=COLS):
  - Request is consumed; err=1 for exactly one cycle (T+1).
  - No writes, no done pulse; FSM stays in IDLE, so req_ready stays 1.
- req_valid while busy: ignored, not queued; the requester must hold valid until ready.
- Outputs buf_we/buf_addr/buf_wdata are registered.
- done and err are never both high.

Test Plan:
- Hex write: op=00, row=15, col=10, data=0x1234ABCD → 10 consecutive writes to addr 1210..1219 with data 30,78,31,32,33,34,61,62,63,64; done at T+11.
- Column wrap: op=00, row=2, col=75, data=0x0000000F → addrs 235..239 then 240..244; last char 0x66; done pulses once.
- Screen wrap plus back-to-back: op=01, row=29, col=79, data=0x41 → single write addr 2399 data 0x41. Immediately accept op=00 at row=29, col=79 → second char lands at addr 0.
- Clear: op=10 → 2400 writes of 0x20, addrs 0..2399 contiguous, busy high throughout, req_ready low; done at T+2401.
- Rejects: op=11, then op=00 with row=30, then op=01 with col=80 → each gives an err pulse only; buf_we stays 0, req_ready stays 1.
- Reset mid-clear: assert Reset_n=0 at write 500 → buf_we drops asynchronously, all outputs 0. After release, a new op=01 executes normally and no leftover clear writes appear.

Source files
------------

// File: rtl/hex_text_writer_if.sv
// hex_text_writer_if: request port and character-buffer write port of hex_text_writer
interface hex_text_writer_if #(parameter int ADDR_W = 12);
  logic              req_valid;
  logic              req_ready;
  logic [1:0]        req_op;
  logic [4:0]        req_row;
  logic [6:0]        req_col;
  logic [31:0]       req_data;
  logic              buf_we;
  logic [ADDR_W-1:0] buf_addr;
  logic [7:0]        buf_wdata;
  logic              busy;
  logic              done;
  logic              err;
  modport slave (
    input  req_valid, req_op, req_row, req_col, req_data,
    output req_ready, buf_we, buf_addr, buf_wdata, busy, done, err
  );
  modport master (
    output req_valid, req_op, req_row, req_col, req_data,
    input  req_ready, buf_we, buf_addr, buf_wdata, busy, done, err
  );
endinterface

// File: rtl/hex_text_writer.sv
// hex_text_writer: writes hex words, single chars or a full clear into the VGA character buffer
module hex_text_writer #(
  parameter int COLS   = 80,
  parameter int ROWS   = 30,
  parameter int ADDR_W = 12
) (
  input logic              Clk,
  input logic              Reset_n,
  hex_text_writer_if.slave bus
);
  localparam int CELLS = COLS * ROWS;
  localparam int CW    = $clog2(CELLS + 1);
  typedef enum logic {IDLE, EMIT} state_t;
  state_t            state_q, state_d;
  logic [1:0]        op_q, op_d;
  logic [31:0]       data_q, data_d;
  logic [4:0]        row_q, row_d;
  logic [6:0]        col_q, col_d;
  logic [CW-1:0]     cnt_q, cnt_d;
  logic              ready_q, ready_d;
  logic              we_q, we_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [7:0]        wdata_q, wdata_d;
  logic              done_q, done_d;
  logic              rej_q, rej_d;
  logic              err_q, err_d;
  logic              accept, clr, req_ok, col_end, row_end;
  logic [CW-1:0]     n_w;
  logic [3:0]        nib;
  logic [7:0]        hex_ch, char_w;
  logic [ADDR_W-1:0] cur_addr;
  assign accept   = bus.req_valid && ready_q;
  assign clr      = bus.req_op == 2'b10;
  assign req_ok   = clr || (bus.req_op != 2'b11 && 32'(bus.req_row) < ROWS && 32'(bus.req_col) < COLS);
  assign n_w      = op_q == 2'b00 ? CW'(10) : op_q == 2'b01 ? CW'(1) : CW'(CELLS);
  assign nib      = data_q[31:28];
  assign hex_ch   = nib <= 4'd9 ? 8'h30 + {4'h0, nib} : 8'h57 + {4'h0, nib};
  assign char_w   = op_q == 2'b01 ? data_q[7:0] : op_q == 2'b10 ? 8'h20 :
                    cnt_q == '0 ? 8'h30 : cnt_q == CW'(1) ? 8'h78 : hex_ch;
  assign col_end  = 32'(col_q) == COLS - 1;
  assign row_end  = 32'(row_q) == ROWS - 1;
  assign cur_addr = ADDR_W'(32'(row_q) * COLS + 32'(col_q));
  // next state: accept/reject in IDLE, one character per cycle in EMIT, done after the last
  always_comb begin
    state_d = state_q;
    op_d    = op_q;
    data_d  = data_q;
    row_d   = row_q;
    col_d   = col_q;
    cnt_d   = cnt_q;
    we_d    = 1'b0;
    addr_d  = addr_q;
    wdata_d = wdata_q;
    done_d  = 1'b0;
    rej_d   = 1'b0;
    err_d   = rej_q;
    if (state_q == IDLE) begin
      if (accept && req_ok) begin
        state_d = EMIT;
        op_d    = bus.req_op;
        data_d  = bus.req_data;
        row_d   = clr ? '0 : bus.req_row;
        col_d   = clr ? '0 : bus.req_col;
        cnt_d   = '0;
      end
      rej_d = accept && !req_ok;
    end else if (cnt_q == n_w) begin
      state_d = IDLE;
      done_d  = 1'b1;
    end else begin
      we_d    = 1'b1;
      addr_d  = cur_addr;
      wdata_d = char_w;
      cnt_d   = cnt_q + CW'(1);
      data_d  = (op_q == 2'b00 && cnt_q >= CW'(2)) ? {data_q[27:0], 4'h0} : data_q;
      col_d   = col_end ? '0 : col_q + 7'd1;
      row_d   = !col_end ? row_q : row_end ? '0 : row_q + 5'd1;
    end
    ready_d = state_d == IDLE;
  end
  // state and registered outputs; reset abandons any sequence in flight
  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) begin
      state_q <= IDLE;
      op_q    <= '0;
      data_q  <= '0;
      row_q   <= '0;
      col_q   <= '0;
      cnt_q   <= '0;
      ready_q <= 1'b0;
      we_q    <= 1'b0;
      addr_q  <= '0;
      wdata_q <= '0;
      done_q  <= 1'b0;
      rej_q   <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      op_q    <= op_d;
      data_q  <= data_d;
      row_q   <= row_d;
      col_q   <= col_d;
      cnt_q   <= cnt_d;
      ready_q <= ready_d;
      we_q    <= we_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
      done_q  <= done_d;
      rej_q   <= rej_d;
      err_q   <= err_d;
    end
  end
  assign bus.req_ready = ready_q;
  assign bus.buf_we    = we_q;
  assign bus.buf_addr  = addr_q;
  assign bus.buf_wdata = wdata_q;
  assign bus.busy      = state_q == EMIT;
  assign bus.done      = done_q;
  assign bus.err       = err_q;
endmodule
